decode_fifo: RTL and testbench
==============================

DECODE_FIFO -- requirements
Module: decode_fifo

Interface
REQ-001 Parameter DEPTH, 4, number of buffered 2-bit codes; SHALL be a power of two, 2..16.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-004 Port a1, input, 1, code MSB; port a0, input, 1, code LSB.
REQ-005 Port in_valid, input, 1, the producer presents a code on a1/a0.
REQ-006 Port in_ready, output, 1, the block can accept a code this cycle.
REQ-007 Ports d3, d2, d1, d0, output, 1 each, one-hot decode of the head code.
REQ-008 Port out_valid, output, 1, d3..d0 hold a valid decoded word.
REQ-009 Port out_ready, input, 1, the consumer takes the word this cycle.
REQ-010 Port level, output, log2(DEPTH)+1, number of buffered codes.
REQ-011 Port count, output, 8, number of words delivered since reset, saturating.

Function
REQ-012 Push SHALL occur on a rising edge with in_valid=1 and in_ready=1, writing {a1,a0} at the tail.
REQ-013 Pop SHALL occur on a rising edge with out_valid=1 and out_ready=1, removing the head.
REQ-014 in_ready SHALL be 1 exactly when level < DEPTH; registered, with no combinational path from out_ready.
REQ-015 out_valid SHALL be 1 exactly when level > 0.
REQ-016 When out_valid=1, d[i]=1 only for i={head a1,a0}: 00->d0, 01->d1, 10->d2, 11->d3.
REQ-017 When out_valid=0, d3..d0 SHALL all be 0.
REQ-018 Latency: a code pushed into an empty buffer at edge N SHALL appear on d3..d0 with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-019 Occupancy states: EMPTY (level=0), PARTIAL (0<level<DEPTH), FULL (level=DEPTH).
REQ-020 Level transitions: push only -> level+1; pop only -> level-1; push and pop together -> level unchanged, head advances, tail written.
REQ-021 In FULL, in_ready=0, so a simultaneous pop SHALL NOT be paired with a push that cycle.
REQ-022 In EMPTY, out_valid=0, so out_ready SHALL be ignored and level SHALL NOT underflow.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Order SHALL be FIFO; no code is dropped or duplicated.
REQ-025 count SHALL increment by 1 on each pop and hold at 255.
REQ-026 in_valid with in_ready=0 SHALL change no state; the producer holds its code.
REQ-027 out_valid and the d outputs SHALL stay stable until popped.

Reset
REQ-028 rst_n=0 SHALL immediately force level=0, count=0, out_valid=0, in_ready=1, d3..d0=0000, and both pointers to 0.
REQ-029 Reset mid-operation SHALL discard all buffered codes.
REQ-030 The first push SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-031 Reset, then push 00,01,10,11 with out_ready=0 -> level=4, in_ready=0, d3..d0=0001.
REQ-032 Continue from REQ-031 with out_ready=1 for 4 cycles -> d3..d0 sequence 0001,0010,0100,1000, then 0000; out_valid=0; count=4.
REQ-033 Push and pop together at level=2 for 10 cycles with a rotating code -> level stays 2; outputs lag inputs by 2 words; pointers wrap correctly.
REQ-034 Full buffer, in_valid=1 with code 11, out_ready=1 for one cycle -> level=3; the code 11 is not accepted that edge.
REQ-035 Assert rst_n=0 asynchronously at level=3 -> outputs 0000, out_valid=0, level=0 before the next clock edge.
REQ-036 Run 300 pops -> count=255 and holds.

Source files
------------

// File: rtl/decode_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_fifo                                                        |
// | FIFO of 2-bit codes; the head code is presented one-hot on d3..d0. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module decode_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a1,
    input  logic                     a0,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     d3,
    output logic                     d2,
    output logic                     d1,
    output logic                     d0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               count
);

    localparam int                  c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_full    = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_lvl_one = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [1:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_level;
    logic [7:0]          r_count;
    logic                r_in_ready;

    logic                w_push;
    logic                w_pop;
    logic [c_addr_w:0]   w_level_next;
    logic [1:0]          w_head;

    assign out_valid = (r_level != '0);
    assign in_ready  = r_in_ready;
    assign level     = r_level;
    assign count     = r_count;
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + c_lvl_one;
            2'b01:   w_level_next = r_level - c_lvl_one;
            default: w_level_next = r_level;
        endcase
    end

    // in_ready is precomputed from the next level so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b1;
            r_count    <= '0;
        end else begin
            r_level    <= w_level_next;
            r_in_ready <= (w_level_next < c_full);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                if (r_count != 8'hFF) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    // Storage needs no reset: stale entries are never visible while level is 0
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {a1, a0};
        end
    end

    assign d0 = out_valid && (w_head == 2'b00);
    assign d1 = out_valid && (w_head == 2'b01);
    assign d2 = out_valid && (w_head == 2'b10);
    assign d3 = out_valid && (w_head == 2'b11);

endmodule
`default_nettype wire

// File: tb/tb_decode_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_decode_fifo                                                     |
// | Scoreboard bench for decode_fifo against a queue reference model.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_decode_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       a1;
    logic       a0;
    logic       in_valid;
    logic       in_ready;
    logic       d3;
    logic       d2;
    logic       d1;
    logic       d0;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic [7:0] count;

    logic [3:0] exp_q [$];
    int         model_count;
    int         n_vec;
    int         n_err;

    decode_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a1        (a1),
        .a0        (a0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One bus cycle: present inputs, decide acceptance at mid-cycle, record it at the edge
    task automatic drive(input logic iv, input logic [1:0] code, input logic ordy);
        logic acc;
        in_valid  = iv;
        {a1, a0}  = code;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
        @(posedge clk);
        if (acc) exp_q.push_back(4'b0001 << code);
        #1;
    endtask

    // Monitor: compares the DUT against the queue model every mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_count = 0;
            end else begin
                chk("level", 32'(level), 32'(exp_q.size()));
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
                chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
                chk("count", 32'(count), 32'(model_count));
                if (exp_q.size() > 0) begin
                    chk("dword", 32'({d3, d2, d1, d0}), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (model_count < 255) model_count++;
                    end
                end else begin
                    chk("dword_idle", 32'({d3, d2, d1, d0}), 32'd0);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_count = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a1 = 1'b0;
        a0 = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_dword", 32'({d3, d2, d1, d0}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with 00,01,10,11 while the consumer stalls
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 1'b0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_dword", 32'({d3, d2, d1, d0}), 32'b0001);

        // Drain
        for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 1'b1);
        chk("drain_dword", 32'({d3, d2, d1, d0}), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd4);

        // Steady push+pop at level 2 with a rotating code
        for (int i = 0; i < 2; i++) drive(1'b1, 2'(i), 1'b0);
        for (int i = 2; i < 12; i++) drive(1'b1, 2'(i % 4), 1'b1);
        chk("steady_level", 32'(level), 32'd2);

        // Fill up, then a push attempt against a full buffer while popping
        for (int i = 0; i < 2; i++) drive(1'b1, 2'(i + 1), 1'b0);
        chk("full_level", 32'(level), 32'd4);
        drive(1'b1, 2'b11, 1'b1);
        chk("full_pop_level", 32'(level), 32'd3);

        // Asynchronous reset mid-operation at level 3
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_dword", 32'({d3, d2, d1, d0}), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0);
        end

        // Long streaming run to saturate the delivered-word counter
        for (int i = 0; i < 310; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
        chk("count_sat", 32'(count), 32'd255);
        drive(1'b0, 2'b00, 1'b1);
        chk("count_hold", 32'(count), 32'd255);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
